// File: rtl/fwd_pkg.sv
// Shared types and code constants for the forwarding-select generator.
package fwd_pkg;
    localparam int REG_AW = 5;
    localparam int NLANE  = 4;
    localparam int NTAG   = 2 * NLANE;

    typedef logic [3:0]        fwd_sel_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam fwd_sel_t FWD_RF   = 4'd0;
    localparam fwd_sel_t FWD_EX0  = 4'd1;
    localparam fwd_sel_t FWD_MEM0 = 4'd5;

    typedef struct packed {
        logic      v;
        reg_addr_t wa;
        logic      ld;
    } fwd_tag_t;
endpackage

// File: rtl/fwd_lookup.sv
// Priority match of one source address against the incoming and EX producer tags.
// tags[0..3] are the incoming issue lanes, tags[4..7] the current EX lanes.
module fwd_lookup
    import fwd_pkg::*;
(
    input  reg_addr_t               ra,
    input  fwd_tag_t [NTAG-1:0]     tags,
    output fwd_sel_t                sel,
    output logic                    haz
);

    logic win_ld;
    logic win_iss;

    // Later assignments override earlier ones, so scan oldest to youngest.
    always_comb begin
        sel     = FWD_RF;
        win_ld  = 1'b0;
        win_iss = 1'b0;
        if (ra != '0) begin
            for (int i = 0; i < NLANE; i++) begin
                if (tags[NLANE+i].v && tags[NLANE+i].wa == ra) begin
                    sel     = FWD_MEM0 + 4'(i);
                    win_ld  = tags[NLANE+i].ld;
                    win_iss = 1'b0;
                end
            end
            for (int i = 0; i < NLANE; i++) begin
                if (tags[i].v && tags[i].wa == ra) begin
                    sel     = FWD_EX0 + 4'(i);
                    win_ld  = tags[i].ld;
                    win_iss = 1'b1;
                end
            end
        end
        // A load that has reached MEM has its data; only one still entering EX stalls.
        haz = win_ld & win_iss;
    end

endmodule

// File: rtl/fwd_sel_gen.sv
// Forwarding select-code generator for the four-issue operand muxes.
// Optional load-use hazard flags under FWD_LOAD_HAZARD_EN.
module fwd_sel_gen
    import fwd_pkg::*;
#(
    parameter int NQ = 8,
    parameter int RW = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        iss_we,
    input  logic [4*RW-1:0]   iss_wa,
    input  logic [3:0]        iss_ld,
    input  logic [NQ*RW-1:0]  q_ra,
    output logic [NQ*4-1:0]   q_sel,
    output logic [NQ-1:0]     q_haz
);

    if (RW != REG_AW) begin : g_rw_chk
        $error("fwd_sel_gen: RW must equal fwd_pkg::REG_AW");
    end

    // MEM contents after the edge are the current EX contents, so the
    // retiring MEM group is never consulted and is not kept.
    logic [NLANE-1:0]      ex_v;
    reg_addr_t [NLANE-1:0] ex_wa;
`ifdef FWD_LOAD_HAZARD_EN
    logic [NLANE-1:0]      ex_ld;
`endif

    fwd_tag_t [NTAG-1:0] tags;
    fwd_sel_t [NQ-1:0]   lk_sel;
    logic [NQ-1:0]       lk_haz;

    always_comb begin
        tags = '0;
        for (int l = 0; l < NLANE; l++) begin
            tags[l].v        = iss_we[l];
            tags[l].wa       = iss_wa[l*RW +: RW];
            tags[NLANE+l].v  = ex_v[l];
            tags[NLANE+l].wa = ex_wa[l];
`ifdef FWD_LOAD_HAZARD_EN
            tags[l].ld       = iss_ld[l];
            tags[NLANE+l].ld = ex_ld[l];
`endif
        end
    end

    for (genvar g = 0; g < NQ; g++) begin : g_q
        fwd_lookup u_lookup (
            .ra   (q_ra[g*RW +: RW]),
            .tags (tags),
            .sel  (lk_sel[g]),
            .haz  (lk_haz[g])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_v  <= '0;
            ex_wa <= '0;
            q_sel <= '0;
        end else if (flush) begin
            ex_v  <= '0;
            q_sel <= '0;
        end else if (!stall) begin
            ex_v  <= iss_we;
            for (int l = 0; l < NLANE; l++) ex_wa[l] <= iss_wa[l*RW +: RW];
            q_sel <= lk_sel;
        end
    end

`ifdef FWD_LOAD_HAZARD_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_ld <= '0;
            q_haz <= '0;
        end else if (flush) begin
            ex_ld <= '0;
            q_haz <= '0;
        end else if (!stall) begin
            ex_ld <= iss_ld;
            q_haz <= lk_haz;
        end
    end
`else
    logic unused_ld;
    logic unused_haz;
    assign unused_ld  = ^iss_ld;
    assign unused_haz = ^lk_haz;
    assign q_haz      = '0;
`endif

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Scoreboard bench for fwd_sel_gen: reference model predicts codes per cycle.
module tb_fwd_sel_gen;
    localparam int NQ = 8;
    localparam int RW = 5;

    logic              clk = 1'b0;
    logic              resetn;
    logic              stall, flush;
    logic [3:0]        iss_we, iss_ld;
    logic [4*RW-1:0]   iss_wa;
    logic [NQ*RW-1:0]  q_ra;
    logic [NQ*4-1:0]   q_sel;
    logic [NQ-1:0]     q_haz;

    fwd_sel_gen #(.NQ(NQ), .RW(RW)) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .iss_we(iss_we), .iss_wa(iss_wa), .iss_ld(iss_ld),
        .q_ra(q_ra), .q_sel(q_sel), .q_haz(q_haz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NQ*4-1:0] sel;
        logic [NQ-1:0]   haz;
    } exp_t;

    exp_t       sbq[$];
    exp_t       prev;
    int         checks = 0;
    int         fails  = 0;
    logic [3:0] m_ex_v;
    logic [4:0] m_ex_wa [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] sel_of(input int i);
        return q_sel[i*4 +: 4];
    endfunction

    // Reference: walk producers youngest first, return the first hit.
    function automatic logic [4:0] mlook(input logic [4:0] ra);
        logic h;
        if (ra == 5'd0) return 5'd0;
        for (int l = 3; l >= 0; l--) begin
            if (iss_we[l] && iss_wa[l*RW +: RW] == ra) begin
`ifdef FWD_LOAD_HAZARD_EN
                h = iss_ld[l];
`else
                h = 1'b0;
`endif
                return {h, 4'(l + 1)};
            end
        end
        for (int l = 3; l >= 0; l--)
            if (m_ex_v[l] && m_ex_wa[l] == ra) return {1'b0, 4'(l + 5)};
        return 5'd0;
    endfunction

    task automatic clr_in();
        stall = 0; flush = 0; iss_we = '0; iss_ld = '0; iss_wa = '0; q_ra = '0;
    endtask

    task automatic iss(input int l, input logic [4:0] wa, input logic ld);
        iss_we[l] = 1'b1;
        iss_wa[l*RW +: RW] = wa;
        iss_ld[l] = ld;
    endtask

    task automatic setq(input int i, input logic [4:0] ra);
        q_ra[i*RW +: RW] = ra;
    endtask

    task automatic model_reset();
        m_ex_v = '0;
        prev   = '0;
        for (int l = 0; l < 4; l++) m_ex_wa[l] = '0;
    endtask

    // Predict, push, clock once, pop and compare; returns at the next negedge.
    task automatic step();
        exp_t       e;
        logic [4:0] r;
        e = '0;
        if (flush) begin
            m_ex_v = '0;
        end else if (stall) begin
            e = prev;
        end else begin
            for (int i = 0; i < NQ; i++) begin
                r = mlook(q_ra[i*RW +: RW]);
                e.sel[i*4 +: 4] = r[3:0];
                e.haz[i]        = r[4];
            end
            for (int l = 0; l < 4; l++) begin
                m_ex_v[l]  = iss_we[l];
                m_ex_wa[l] = iss_wa[l*RW +: RW];
            end
        end
        prev = e;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sbq_empty", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            chk("sb_sel", 64'(q_sel), 64'(e.sel));
            chk("sb_haz", 64'(q_haz), 64'(e.haz));
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        resetn = 0;
        stall = 1'b0; flush = 1'b0;
        iss_we = 4'($urandom); iss_ld = 4'($urandom);
        iss_wa = 20'($urandom); q_ra = {$urandom, 8'($urandom)};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", 64'(q_sel), 64'd0);
        chk("rst_haz", 64'(q_haz), 64'd0);
        @(negedge clk);
        clr_in();
        resetn = 1;
        setq(0, 5'd7); setq(1, 5'd9);
        step();
        chk("post_rst_sel", 64'(q_sel), 64'd0);

        // EX then MEM forward of one producer
        clr_in(); iss(2, 5'd7, 1'b0); setq(0, 5'd7);
        step();
        chk("ex_fwd", sel_of(0), 4'd3);
        clr_in(); setq(0, 5'd7);
        step();
        chk("mem_fwd", sel_of(0), 4'd7);

        // Priority
        clr_in(); iss(0, 5'd9, 1'b0); iss(3, 5'd9, 1'b0); setq(0, 5'd9);
        step();
        chk("pri_iss", sel_of(0), 4'd4);
        clr_in(); iss(1, 5'd9, 1'b0); setq(0, 5'd9);
        step();
        chk("pri_iss1", sel_of(0), 4'd2);
        clr_in(); setq(0, 5'd9);
        step();
        chk("pri_ex", sel_of(0), 4'd6);
        clr_in(); iss(1, 5'd9, 1'b0);
        step();
        clr_in(); iss(0, 5'd9, 1'b0); setq(0, 5'd9);
        step();
        chk("pri_iss_over_ex", sel_of(0), 4'd1);

        // r0 and disabled lanes
        clr_in(); iss(0, 5'd0, 1'b0); setq(0, 5'd0);
        step();
        chk("r0", sel_of(0), 4'd0);
        clr_in(); iss_wa[4:0] = 5'd5; setq(0, 5'd5);
        step();
        chk("we0", sel_of(0), 4'd0);

        // Stall holds outputs and stage mapping
        clr_in(); iss(3, 5'd12, 1'b0); setq(1, 5'd12);
        step();
        chk("stall_pre", sel_of(1), 4'd4);
        for (int k = 0; k < 3; k++) begin
            stall = 1; iss_we = 4'($urandom); iss_wa = 20'($urandom);
            q_ra = {$urandom, 8'($urandom)};
            step();
            chk("stall_hold", sel_of(1), 4'd4);
        end
        clr_in(); setq(1, 5'd12);
        step();
        chk("stall_after", sel_of(1), 4'd8);

        // Flush dominates stall and discards the presented group
        clr_in(); iss(0, 5'd3, 1'b0); setq(0, 5'd3);
        step();
        chk("flush_pre", sel_of(0), 4'd1);
        clr_in(); flush = 1; stall = 1; iss(1, 5'd3, 1'b0); setq(0, 5'd3); setq(2, 5'd3);
        step();
        chk("flush_sel", 64'(q_sel), 64'd0);
        chk("flush_haz", 64'(q_haz), 64'd0);
        clr_in(); setq(0, 5'd3);
        step();
        chk("flush_gone", sel_of(0), 4'd0);

        // Load-use hazard
        clr_in(); iss(1, 5'd4, 1'b1); setq(0, 5'd4);
        step();
        chk("ld_sel", sel_of(0), 4'd2);
`ifdef FWD_LOAD_HAZARD_EN
        chk("ld_haz", 64'(q_haz[0]), 64'd1);
`else
        chk("ld_haz_off", 64'(q_haz[0]), 64'd0);
`endif
        clr_in(); setq(0, 5'd4);
        step();
        chk("ld_mem_sel", sel_of(0), 4'd6);
        chk("ld_mem_haz", 64'(q_haz[0]), 64'd0);

        // Randomized traffic on a narrow register range to force collisions
        for (int k = 0; k < 300; k++) begin
            clr_in();
            stall  = ($urandom_range(0, 99) < 15);
            flush  = ($urandom_range(0, 99) < 5);
            iss_we = 4'($urandom);
            iss_ld = 4'($urandom);
            for (int l = 0; l < 4; l++) iss_wa[l*RW +: RW] = 5'($urandom_range(0, 7));
            for (int i = 0; i < NQ; i++) setq(i, 5'($urandom_range(0, 7)));
            step();
        end

        // Asynchronous reset mid-operation
        clr_in(); iss(2, 5'd6, 1'b0); setq(3, 5'd6);
        step();
        chk("mid_pre", sel_of(3), 4'd3);
        #2 resetn = 0;
        #1;
        chk("mid_rst_sel", 64'(q_sel), 64'd0);
        chk("mid_rst_haz", 64'(q_haz), 64'd0);
        model_reset();
        @(negedge clk);
        resetn = 1;
        clr_in(); setq(3, 5'd6);
        step();
        chk("mid_rst_gone", sel_of(3), 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/fwd_sel_gen.md
Name: fwd_sel_gen

Overview:
- Generates the 4-bit forwarding select codes consumed by the 9-input operand muxes of the four-issue pipeline.
- Tracks destination tags of up to 8 in-flight results: 4 lanes in EX and 4 lanes in MEM.
- For each source-operand query, registers the code of the youngest matching producer, or 0 to select the register file.
- Sits between decode/issue and the EX-stage operand muxes. Codes are aligned with operands entering EX.

Parameters:
- NQ, 8, number of query ports (4 lanes x 2 source operands).
- RW, 5, register address width.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- stall  input  1  pipeline hold; all state and outputs hold.
- flush  input  1  clear all tracked producers.
- iss_we  input  4  per-lane write enable of the group issuing this cycle (enters EX next cycle).
- iss_wa  input  4*RW  per-lane destination register, lane0 in the LSBs.
- iss_ld  input  4  per-lane load flag (used only with FWD_LOAD_HAZARD_EN).
- q_ra  input  NQ*RW  query register addresses.
- q_sel  output  NQ*4  registered select codes: 0=regfile, 1-4=EX lane0-3, 5-8=MEM lane0-3.
- q_haz  output  NQ  registered load-use hazard flags.

Behaviour:
- State: ex_v[4], ex_wa[4], ex_ld[4], mem_v[4], mem_wa[4]. Reset and flush clear all valid bits. q_sel resets to 0. q_haz resets to 0.
- Advance (stall=0, flush=0), per clock edge:
  - mem_v/mem_wa <= ex_v/ex_wa.
  - ex_v <= iss_we, ex_wa <= iss_wa, ex_ld <= iss_ld.
  - Each q_sel[i] <= lookup(q_ra[i]). Latency: 1 cycle.
- Lookup evaluates against the state that will exist after the edge:
  - Incoming issue group maps to codes 1-4.
  - Current EX contents map to codes 5-8.
- Priority, youngest first: iss lane3, lane2, lane1, lane0, then ex lane3 down to lane0.
- No match, or q_ra == 0: code 0. Register $0 never forwards, even if a lane writes it.
- A lane with iss_we=0 or ex_v=0 never matches.
- stall=1: all state, q_sel and q_haz hold their values. Inputs are ignored.
- flush=1 (dominates stall):
  - All valid bits cleared.
  - q_sel all 0 and q_haz all 0 on the next edge.
  - The issue group presented in the flush cycle is discarded.
- Codes 9-15 are never produced.
- Intra-group dependences (same-cycle producer and consumer) are the issue logic's responsibility. This block does not detect them.
- Reset asserted mid-operation: immediate asynchronous clear of all state and outputs.

Optional Feature:
- Macro: FWD_LOAD_HAZARD_EN.
- Defined:
  - q_haz[i] <= 1 when the winning match is an incoming issue lane with iss_ld=1, because load data is not available from EX.
  - q_sel[i] still carries that code (1-4).
  - A MEM-stage load match (5-8) is not a hazard.
- Undefined:
  - q_haz is tied to 0.
  - iss_ld is unused.
  - ex_ld registers are not instantiated.

Decomposition:
- Package fwd_pkg holds:
  - localparams FWD_RF=0, FWD_EX0=1, FWD_MEM0=5.
  - typedef fwd_sel_t (logic [3:0]).
  - typedef reg_addr_t (logic [RW-1:0]).
  - struct fwd_tag_t {v, wa, ld}.
- One sub-module, fwd_lookup: combinational priority match of one query address against 8 tags, returning code and hazard. Instantiated NQ times via generate.

Test Plan:
- Reset: hold resetn=0 with random inputs -> q_sel all 0, q_haz all 0. Release with no issue -> still 0.
- EX forward:
  - Issue lane2 we=1 wa=7, query q_ra[0]=7 in the same cycle -> next cycle q_sel[0]=3.
  - One more advance with the same query -> q_sel[0]=7 (MEM lane2).
- Priority:
  - Lanes 0 and 3 both write r9 -> query r9 gives 4.
  - Current EX lane1 writes r9 with no incoming writer of r9 -> query gives 6.
  - Both incoming and EX writers of r9 -> incoming wins.
- r0 and disabled lanes:
  - Lane0 writes wa=0, query r0 -> 0.
  - iss_we=0 with wa=5, query r5 -> 0.
- Stall/flush:
  - stall=1 for 3 cycles -> q_sel unchanged, and the tag later appears with the pre-stall stage mapping.
  - flush=1 together with stall=1 -> all q_sel 0 next cycle, and earlier producers no longer match.
- FWD_LOAD_HAZARD_EN:
  - Issue lane1 ld=1 wa=4, query r4 -> q_sel=2, q_haz=1.
  - Next advance -> q_sel=6, q_haz=0.
  - With the macro undefined -> q_haz always 0.
